// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared types and helpers for the round-robin mux arbiter.
//   arb_state_e : packet-lock FSM states (ARB = free arbitration, LOCK = held
//                 on one requester until its last beat)
//   id_w(n)     : width of a requester index for n requesters
package mux_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Index width; clamps to 1 so a degenerate n still yields a legal vector.
  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational rotating-priority picker.
//   req          in  N    request vector
//   ptr          in  IDW  highest-priority index for this pick
//   grant_onehot out N    one-hot winner, zero when no request
//   grant_id     out IDW  winner index, zero when no request
//   any          out 1    at least one request present
// Scan order is ptr, ptr+1, ... wrapping N-1 -> 0; the first set bit wins.
module rr_priority_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant_onehot,
  output logic [IDW-1:0] grant_id,
  output logic           any
);

  always_comb begin
    int             idx;
    logic [IDW-1:0] sel;
    grant_onehot = '0;
    grant_id     = '0;
    any          = 1'b0;
    idx          = 0;
    sel          = '0;
    for (int k = 0; k < N; k++) begin
      // Modular wrap without a divider: ptr < N and k < N, so one subtract suffices.
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      sel = IDW'(idx);
      if (!any && req[sel]) begin
        any               = 1'b1;
        grant_id          = sel;
        grant_onehot[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: N_REQ valid/ready producers share one registered output
// channel. A round-robin picker chooses the winner, its data goes through an
// N:1 mux into a one-entry output register.
//   clk, rst     clock / asynchronous active-high reset
//   req_valid    per-requester valid
//   req_data     per-requester data, packed [N_REQ-1:0][W-1:0]
//   req_last     per-requester end-of-packet (only with ARB_PACKET_LOCK_EN)
//   req_ready    per-requester ready, one-hot or zero
//   out_valid    output register holds data
//   out_data     data of last winner
//   out_id       index of the requester that produced out_data
//   out_ready    downstream takes out_data this cycle
// Build option: define ARB_PACKET_LOCK_EN to hold the grant on a requester
// from the first beat of a packet through its req_last beat. Without it the
// FSM never leaves ARB and every beat re-arbitrates.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int W     = 8,
  localparam int IDW   = id_w(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0][W-1:0]   req_data,
`ifdef ARB_PACKET_LOCK_EN
  input  logic [N_REQ-1:0]          req_last,
`endif
  output logic [N_REQ-1:0]          req_ready,
  output logic                      out_valid,
  output logic [W-1:0]              out_data,
  output logic [IDW-1:0]            out_id,
  input  logic                      out_ready
);

  typedef logic [W-1:0] data_t;

  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   lock_id;
  logic [IDW-1:0]   pick_ptr;
  logic [IDW-1:0]   grant_id;
  logic [N_REQ-1:0] req_eff;
  logic [N_REQ-1:0] grant_onehot;
  logic [N_REQ-1:0] last;
  logic             any;
  logic             load_en;
  logic             xfer;
  data_t            sel_data;
  arb_state_e       state, state_nxt;

  // Without packet lock every beat is treated as a packet end, so the FSM
  // stays in ARB and the pointer advances on every transfer.
`ifdef ARB_PACKET_LOCK_EN
  assign last = req_last;
`else
  assign last = '1;
`endif

  // ---------------- lock FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ARB;
      lock_id <= '0;
    end else begin
      state <= state_nxt;
      // Recording on every ARB transfer is harmless: lock_id only matters
      // once the FSM has moved to LOCK on that same transfer.
      if (state == ARB && xfer) lock_id <= grant_id;
    end
  end

  // ---------------- lock FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (xfer && !last[grant_id]) state_nxt = LOCK;
      LOCK:    if (xfer &&  last[grant_id]) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // ---------------- lock FSM: outputs ----------------
  // In LOCK only the held requester is visible to the picker.
  always_comb begin
    req_eff  = req_valid;
    pick_ptr = rr_ptr;
    if (state == LOCK) begin
      req_eff          = '0;
      req_eff[lock_id] = req_valid[lock_id];
      pick_ptr         = lock_id;
    end
  end

  rr_priority_pick #(
    .N   (N_REQ),
    .IDW (IDW)
  ) u_pick (
    .req          (req_eff),
    .ptr          (pick_ptr),
    .grant_onehot (grant_onehot),
    .grant_id     (grant_id),
    .any          (any)
  );

  // Output stage can take a beat when empty or draining this cycle.
  assign load_en   = !out_valid || out_ready;
  assign req_ready = load_en ? grant_onehot : '0;
  assign xfer      = load_en && any;
  assign sel_data  = req_data[grant_id];

  // Pointer moves past the winner only at a packet boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (xfer && last[grant_id]) begin
      rr_ptr <= (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  // One-entry output register; data/id held while stalled or empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else if (load_en) begin
      out_valid <= any;
      if (any) begin
        out_data <= sel_data;
        out_id   <= grant_id;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req_valid;
  logic [N-1:0][W-1:0] req_data;
  logic [N-1:0]        req_last;
  logic [N-1:0]        req_ready;
  logic                out_valid;
  logic [W-1:0]        out_data;
  logic [1:0]          out_id;
  logic                out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
`ifdef ARB_PACKET_LOCK_EN
    .req_last  (req_last),
`endif
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [3:0] v;
    logic       r;
    logic [3:0] rdy;
    logic       ov;
    logic [1:0] id;
    logic [7:0] d;
  } vec_t;

  typedef struct {
    int         id;
    logic [7:0] d;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic r, input logic [3:0] rdy,
                              input logic ov, input logic [1:0] id, input logic [7:0] d);
    vec_t t;
    t.v = v; t.r = r; t.rdy = rdy; t.ov = ov; t.id = id; t.d = d;
    return t;
  endfunction

  // First valid index scanning from start with wrap, -1 if none.
  function automatic int rr_first(input logic [3:0] elig, input int start);
    for (int k = 0; k < N; k++)
      if (elig[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    req_last = '1;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_fixed_data();
    for (int i = 0; i < N; i++) req_data[i] = 8'(i * 16 + 1);
  endtask

  // Drive one cycle, check combinational ready, then registered outputs after the edge.
  task automatic step(input string tag, input logic [3:0] v, input logic [3:0] lst, input logic r,
                      input logic [3:0] rdy, input logic ov, input logic [1:0] id, input logic [7:0] d);
    @(negedge clk);
    req_valid = v; req_last = lst; out_ready = r;
    #1;
    chk({tag, " req_ready"}, 32'(req_ready), 32'(rdy));
    @(posedge clk);
    #1;
    chk({tag, " out_valid"}, 32'(out_valid), 32'(ov));
    if (ov) begin
      chk({tag, " out_id"}, 32'(out_id), 32'(id));
      chk({tag, " out_data"}, 32'(out_data), 32'(d));
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_last = '1; out_ready = 1'b0;
    set_fixed_data();

    // ---------- reset state ----------
    do_reset();
    #1;
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset out_id", 32'(out_id), 0);
    chk("reset out_data", 32'(out_data), 0);

    // ---------- table: rotation, stall, wrap, drain, single requester ----------
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(4'hF, 1'b1, 4'(1 << (k % 4)), 1'b1, 2'(k % 4), 8'((k % 4) * 16 + 1)));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(4'hF, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h01));
    tbl.push_back(mk(4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h21));
    tbl.push_back(mk(4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h31));
    tbl.push_back(mk(4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h01));
    tbl.push_back(mk(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h01));
    tbl.push_back(mk(4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h11));
    tbl.push_back(mk(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 8'h11));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h21));
    for (int k = 0; k < tbl.size(); k++)
      step($sformatf("vec%0d", k), tbl[k].v, 4'hF, tbl[k].r, tbl[k].rdy, tbl[k].ov, tbl[k].id, tbl[k].d);

    // ---------- reset mid-transfer ----------
    do_reset();
    step("mid a", 4'b0010, 4'hF, 1'b0, 4'b0010, 1'b1, 2'd1, 8'h11);
    step("mid b", 4'b0000, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h11);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst out_valid", 32'(out_valid), 0);
    chk("async rst out_id", 32'(out_id), 0);
    chk("async rst out_data", 32'(out_data), 0);
    @(negedge clk);
    rst = 1'b0;
    step("post rst ptr", 4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h01);

`ifdef ARB_PACKET_LOCK_EN
    // ---------- packet lock: req1 waits for req0's last beat ----------
    do_reset();
    step("lock b1", 4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h01);
    step("lock b2", 4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h01);
    step("lock b3", 4'b0011, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h01);
    step("lock r1", 4'b0011, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11);
    step("lock r2", 4'b0011, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11);
`endif

    // ---------- randomized run against a reference model ----------
    do_reset();
    begin
      bit         m_ov = 0;
      int         m_ptr = 0;
      bit         m_lock = 0;
      int         m_lid = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        logic [3:0] elig;
        logic [3:0] exp_rdy;
        bit         load;
        int         w;
        sb_t        e;
        @(negedge clk);
        req_valid = 4'($urandom_range(0, 15));
        for (int i = 0; i < N; i++) req_data[i] = 8'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
`ifdef ARB_PACKET_LOCK_EN
        req_last = 4'($urandom);
`else
        req_last = '1;
`endif
        #1;
        load = !m_ov || out_ready;
        elig = m_lock ? (req_valid & 4'(1 << m_lid)) : req_valid;
        w = rr_first(elig, m_lock ? m_lid : m_ptr);
        exp_rdy = (load && w >= 0) ? 4'(1 << w) : 4'b0;
        chk("rand req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rand onehot0", 32'($onehot0(req_ready)), 1);
        chk("rand out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
          if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rand scoreboard actual=nonempty-output required=no-pending-entry");
          end else begin
            chk("rand out_id", 32'(out_id), 32'(sb[0].id));
            chk("rand out_data", 32'(out_data), 32'(sb[0].d));
            if (out_ready) void'(sb.pop_front());
          end
        end
        if (load) begin
          if (w >= 0) begin
            m_ov = 1;
            e.id = w; e.d = req_data[w];
            sb.push_back(e);
            if (!m_lock) begin
              if (!req_last[w]) begin m_lock = 1; m_lid = w; end
              else m_ptr = (w + 1) % N;
            end else if (req_last[w]) begin
              m_lock = 0;
              m_ptr = (w + 1) % N;
            end
          end else begin
            m_ov = 0;
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
